// File: rtl/qam_mapper_if.sv
// Bus bundle shared by the upstream (word) and downstream (symbol) sides of qam_mapper.
// The master drives cycle, strobe, write and data; the slave returns the acknowledge.
interface qam_mapper_if;
    logic        cyc;
    logic        stb;
    logic        we;
    logic        ack;
    logic [31:0] dat;

    modport master (output cyc, output stb, output we, output dat, input ack);
    modport slave  (input cyc, input stb, input we, input dat, output ack);
endinterface

// File: rtl/qam_mapper.sv
// Packs upstream 32-bit words into a 64-bit bit buffer and emits one QPSK/16QAM/64QAM
// complex symbol ({Q, I}, Q1.15) per downstream handshake.
module qam_mapper #(
    parameter logic [15:0] P_QPSK  = 16'h7FFF,
    parameter logic [15:0] P_Q16_1 = 16'h2AAA,
    parameter logic [15:0] P_Q16_3 = 16'h7FFE,
    parameter logic [15:0] P_Q64_1 = 16'h1249,
    parameter logic [15:0] P_Q64_3 = 16'h36DB,
    parameter logic [15:0] P_Q64_5 = 16'h5B6D,
    parameter logic [15:0] P_Q64_7 = 16'h7FFF
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [1:0]   mod_i,
    qam_mapper_if.slave  up_if,
    qam_mapper_if.master dn_if
);

    typedef enum logic [1:0] {ModQpsk = 2'd0, Mod16 = 2'd1, Mod64 = 2'd2} mod_e;

    logic        cyc_in_q;
    mod_e        mode_q, mode_d, mode_c;
    logic [6:0]  cnt_q, cnt_d, cnt_b, cnt_m, bps_c, bps_cur;
    logic [63:0] buf_q, buf_d, buf_b, merged;
    logic [31:0] dat_q, dat_d;
    logic        stb_q, stb_d, cyc_o_q, cyc_o_d;
    logic        cyc_rise, ena, ack, ld;
    logic [15:0] sym_i, sym_q;

    function automatic logic [6:0] bps_of(input mod_e m);
        case (m)
            Mod16:   return 7'd4;
            Mod64:   return 7'd6;
            default: return 7'd2;
        endcase
    endfunction

    function automatic logic [15:0] lvl16(input logic b0, input logic b1);
        logic [15:0] mag;
        mag = b1 ? P_Q16_1 : P_Q16_3;
        return b0 ? mag : 16'd0 - mag;
    endfunction

    // b[0] selects the sign; {b[1], b[2]} is the Gray-coded magnitude.
    function automatic logic [15:0] lvl64(input logic [2:0] b);
        logic [15:0] mag;
        case ({b[1], b[2]})
            2'b00:   mag = P_Q64_7;
            2'b01:   mag = P_Q64_5;
            2'b11:   mag = P_Q64_3;
            default: mag = P_Q64_1;
        endcase
        return b[0] ? mag : 16'd0 - mag;
    endfunction

    assign cyc_rise = up_if.cyc & ~cyc_in_q;
    assign ena      = up_if.cyc & up_if.stb & up_if.we;

    always_comb begin
        mode_c = mode_q;
        if (cyc_rise) begin
            mode_c = (mod_i == 2'b11) ? ModQpsk : mod_e'(mod_i);
        end
        bps_c   = bps_of(mode_c);
        bps_cur = bps_of(mode_q);
        // A new burst starts from an empty buffer; the clear takes effect this cycle.
        cnt_b   = cyc_rise ? 7'd0 : cnt_q;
        buf_b   = cyc_rise ? 64'd0 : buf_q;
        ack     = ena & cyc_o_q & (cnt_b <= 7'd32);
        merged  = ack ? (buf_b | ({32'd0, up_if.dat} << cnt_b)) : buf_b;
        cnt_m   = ack ? cnt_b + 7'd32 : cnt_b;
        // The incoming word is merged before the load check so its first symbol leaves
        // on the very next cycle.
        ld      = (cnt_m >= bps_c) & (~stb_q | dn_if.ack);
    end

    always_comb begin
        sym_i = 16'd0;
        sym_q = 16'd0;
        case (mode_c)
            Mod16: begin
                sym_i = lvl16(merged[0], merged[1]);
                sym_q = lvl16(merged[2], merged[3]);
            end
            Mod64: begin
                sym_i = lvl64(merged[2:0]);
                sym_q = lvl64(merged[5:3]);
            end
            default: begin
                sym_i = merged[0] ? 16'd0 - P_QPSK : P_QPSK;
                sym_q = merged[1] ? 16'd0 - P_QPSK : P_QPSK;
            end
        endcase
    end

    always_comb begin
        mode_d  = mode_c;
        buf_d   = ld ? merged >> bps_c : merged;
        cnt_d   = ld ? cnt_m - bps_c : cnt_m;
        dat_d   = ld ? {sym_q, sym_i} : dat_q;
        stb_d   = ld ? 1'b1 : (stb_q & ~dn_if.ack);
        cyc_o_d = cyc_o_q;
        if (cyc_rise) begin
            cyc_o_d = 1'b1;
        end else if (~up_if.cyc && (cnt_q < bps_cur) && (~stb_q || dn_if.ack)) begin
            cyc_o_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        // Tracks the bus even through reset so a burst held open across reset is not
        // mistaken for a new one.
        cyc_in_q <= up_if.cyc;
        if (rst_i) begin
            mode_q  <= ModQpsk;
            cnt_q   <= 7'd0;
            buf_q   <= 64'd0;
            dat_q   <= 32'd0;
            stb_q   <= 1'b0;
            cyc_o_q <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            dat_q   <= dat_d;
            stb_q   <= stb_d;
            cyc_o_q <= cyc_o_d;
        end
    end

    assign up_if.ack = ack;
    assign dn_if.cyc = cyc_o_q;
    assign dn_if.stb = stb_q;
    assign dn_if.we  = stb_q;
    assign dn_if.dat = dat_q;

endmodule

// File: tb/tb_qam_mapper.sv
// Directed bench for qam_mapper: table of single-burst vectors plus hand-written
// backpressure, mode-change and mid-burst reset sequences.
module tb_qam_mapper;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] mod = 2'b00;

    qam_mapper_if up();
    qam_mapper_if dn();

    qam_mapper dut (
        .clk_i (clk),
        .rst_i (rst),
        .mod_i (mod),
        .up_if (up),
        .dn_if (dn)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  mode;
        logic [31:0] word;
        int          nw;
        int          nsym;
        logic [31:0] s0;
        logic [31:0] s1;
        logic [31:0] srest;
    } vec_t;

    vec_t        vecs[11];
    logic [31:0] syms[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc_n = 0;
    int          first_ack = -1;
    int          first_stb = -1;
    int          first_cyco = -1;
    int          rise_n = 0;

    // Downstream sink: a transfer completes at the next rising edge when stb and ack are high.
    initial begin
        forever begin
            @(negedge clk);
            cyc_n++;
            if (dn.stb && dn.ack) syms.push_back(dn.dat);
            if (up.ack && first_ack < 0) first_ack = cyc_n;
            if (dn.stb && first_stb < 0) first_stb = cyc_n;
            if (dn.cyc && first_cyco < 0) first_cyco = cyc_n;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_syms(input string name, input int n, input logic [31:0] s0,
                              input logic [31:0] s1, input logic [31:0] sr);
        logic [31:0] e, g;
        chk({name, " count"}, syms.size(), n);
        for (int i = 0; i < n; i++) begin
            e = (i == 0) ? s0 : (i == 1) ? s1 : sr;
            g = (i < syms.size()) ? syms[i] : 32'hxxxxxxxx;
            chk($sformatf("%s sym%0d", name, i), g, e);
        end
    endtask

    task automatic drive_burst(input logic [1:0] mode, input logic [31:0] w0,
                               input logic [31:0] w1, input logic [31:0] w2, input int n);
        logic [31:0] w[3];
        logic        acc;
        int          k, g;
        w[0] = w0; w[1] = w1; w[2] = w2;
        @(posedge clk); #1;
        first_ack = -1; first_stb = -1; first_cyco = -1;
        rise_n = cyc_n + 1;
        mod = mode; up.cyc = 1'b1; up.stb = 1'b1; up.we = 1'b1; up.dat = w[0];
        k = 0; g = 0;
        while (k < n && g < 200) begin
            @(negedge clk);
            acc = up.ack;
            @(posedge clk); #1;
            g++;
            if (acc) begin
                k++;
                if (k < n) up.dat = w[k];
                else up.stb = 1'b0;
            end
        end
        chk("words accepted", k, n);
        up.stb = 1'b0; up.cyc = 1'b0; up.we = 1'b0;
        g = 0;
        while (dn.cyc && g < 300) begin
            @(posedge clk); #1;
            g++;
        end
        chk("cyc_o falls", {31'd0, dn.cyc}, 32'd0);
    endtask

    logic [31:0] stall_exp[16];
    int          g;

    initial begin
        vecs[0]  = '{2'b00, 32'h00000000, 1, 16, 32'h7FFF7FFF, 32'h7FFF7FFF, 32'h7FFF7FFF};
        vecs[1]  = '{2'b00, 32'h0000000E, 1, 16, 32'h80017FFF, 32'h80018001, 32'h7FFF7FFF};
        vecs[2]  = '{2'b11, 32'hFFFFFFFF, 1, 16, 32'h80018001, 32'h80018001, 32'h80018001};
        vecs[3]  = '{2'b01, 32'h00000000, 1, 8, 32'h80028002, 32'h80028002, 32'h80028002};
        vecs[4]  = '{2'b01, 32'hAAAAAAAA, 1, 8, 32'hD556D556, 32'hD556D556, 32'hD556D556};
        vecs[5]  = '{2'b01, 32'h0000000E, 1, 8, 32'h2AAAD556, 32'h80028002, 32'h80028002};
        vecs[6]  = '{2'b10, 32'hFFFFFFFF, 2, 10, 32'h36DB36DB, 32'h36DB36DB, 32'h36DB36DB};
        vecs[7]  = '{2'b10, 32'h00000015, 1, 5, 32'hEDB75B6D, 32'h80018001, 32'h80018001};
        vecs[8]  = '{2'b10, 32'h00000F80, 1, 5, 32'h80018001, 32'h36DBC925, 32'h80018001};
        vecs[9]  = '{2'b10, 32'h0000000E, 1, 5, 32'h7FFFC925, 32'h80018001, 32'h80018001};
        vecs[10] = '{2'b01, 32'h55555555, 1, 8, 32'h7FFE7FFE, 32'h7FFE7FFE, 32'h7FFE7FFE};
        for (int i = 0; i < 16; i++) stall_exp[i] = 32'h80018001;
        stall_exp[0] = 32'h7FFFC925;
        stall_exp[5] = 32'hEDB7A493;
        stall_exp[6] = 32'h80017FFF;

        up.cyc = 1'b0; up.stb = 1'b0; up.we = 1'b0; up.dat = 32'd0;
        dn.ack = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset stb_o", {31'd0, dn.stb}, 32'd0);
        chk("reset cyc_o", {31'd0, dn.cyc}, 32'd0);
        chk("reset we_o", {31'd0, dn.we}, 32'd0);
        chk("reset dat_o", dn.dat, 32'd0);
        chk("reset ack_o", {31'd0, up.ack}, 32'd0);

        foreach (vecs[v]) begin
            syms.delete();
            drive_burst(vecs[v].mode, vecs[v].word, vecs[v].word, 32'd0, vecs[v].nw);
            check_syms($sformatf("vec%0d", v), vecs[v].nsym, vecs[v].s0, vecs[v].s1,
                       vecs[v].srest);
            chk($sformatf("vec%0d cyc_o rise", v), first_cyco - rise_n, 1);
            chk($sformatf("vec%0d first ack", v), first_ack - rise_n, 1);
            chk($sformatf("vec%0d stb latency", v), first_stb - first_ack, 1);
        end

        // Backpressure: sink stalled from the burst start; third word must wait.
        syms.delete();
        dn.ack = 1'b0;
        fork
            drive_burst(2'b10, 32'h0000000E, 32'h00000015, 32'h00000000, 3);
            begin
                g = 0;
                while (!dn.stb && g < 50) begin
                    @(posedge clk); #1;
                    g++;
                end
                repeat (3) @(posedge clk);
                for (int c = 0; c < 16; c++) begin
                    @(negedge clk);
                    chk("stall stb_o", {31'd0, dn.stb}, 32'd1);
                    chk("stall dat_o", dn.dat, 32'h7FFFC925);
                    chk("stall ack_o", {31'd0, up.ack}, 32'd0);
                end
                @(posedge clk); #1;
                dn.ack = 1'b1;
            end
        join
        chk("stall count", syms.size(), 16);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("stall sym%0d", i), (i < syms.size()) ? syms[i] : 32'hxxxxxxxx,
                stall_exp[i]);
        end

        // MOD_I switched to 64QAM after the first word; the burst stays QPSK.
        syms.delete();
        fork
            drive_burst(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 2);
            begin
                g = 0;
                do begin
                    @(negedge clk);
                    g++;
                end while (!up.ack && g < 50);
                @(posedge clk); #1;
                mod = 2'b10;
            end
        join
        check_syms("modechg", 32, 32'h80018001, 32'h80018001, 32'h80018001);
        syms.delete();
        drive_burst(2'b10, 32'h00000000, 32'd0, 32'd0, 1);
        check_syms("next burst", 5, 32'h80018001, 32'h80018001, 32'h80018001);

        // Reset pulse mid-burst: 16QAM, cnt at 20 with a symbol pending.
        syms.delete();
        @(posedge clk); #1;
        mod = 2'b01; up.cyc = 1'b1; up.stb = 1'b1; up.we = 1'b1; up.dat = 32'hFFFFFFFF;
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (!up.ack && g < 20);
        @(posedge clk); #1;
        up.stb = 1'b0;
        g = 0;
        while (syms.size() < 2 && g < 50) begin
            @(posedge clk); #1;
            g++;
        end
        chk("pre-reset sym0", syms[0], 32'h2AAA2AAA);
        chk("pre-reset stb_o", {31'd0, dn.stb}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("post-reset stb_o", {31'd0, dn.stb}, 32'd0);
        chk("post-reset cyc_o", {31'd0, dn.cyc}, 32'd0);
        chk("post-reset dat_o", dn.dat, 32'd0);
        up.stb = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("held stb_o", {31'd0, dn.stb}, 32'd0);
            chk("held ack_o", {31'd0, up.ack}, 32'd0);
        end
        @(posedge clk); #1;
        up.cyc = 1'b0; up.stb = 1'b0; up.we = 1'b0;
        syms.delete();
        drive_burst(2'b01, 32'h0000000E, 32'd0, 32'd0, 1);
        check_syms("after reset", 8, 32'h2AAAD556, 32'h80028002, 32'h80028002);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
